// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports; optional round-robin via ARB_RR_EN.
// Latency: request seen in IDLE at cycle 0 -> mem_en in cycle 1 -> ack in cycle MEM_LAT+2.
// Backpressure: requesters hold req until their one-cycle ack; the non-granted port simply waits.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              gnt_d;
    logic              hold_we;
    logic              any_req;
    logic              pick_d;
    logic              grant_now;
    logic              cap_last;

    logic              busy_nxt;
    logic              mem_en_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              i_ack_nxt;
    logic              d_ack_nxt;

    assign any_req   = i_req | d_req;
    assign grant_now = (state == ST_IDLE) && any_req;
    assign cap_last  = (state == ST_WAIT) && (cnt == 4'd1);

`ifdef ARB_RR_EN
    logic last_d;

    // Remember which port won the most recent grant (reset: fetch, so data wins the first tie).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (grant_now) begin
            last_d <= pick_d;
        end
    end

    // On a tie hand the grant to the port that did not win last time.
    always_comb begin
        pick_d = d_req;
        if (d_req && i_req) begin
            pick_d = !last_d;
        end
    end
`else
    // Fixed priority: data always beats fetch.
    always_comb begin
        pick_d = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one issue cycle, count out the memory latency, one response cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == 4'd1) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the memory command regs double as the holding regs.
    always_comb begin
        busy_nxt      = (state_nxt != ST_IDLE);
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        if (grant_now) begin
            mem_en_nxt = 1'b1;
            if (pick_d) begin
                mem_we_nxt    = d_we;
                mem_addr_nxt  = d_addr;
                mem_wdata_nxt = d_wdata;
            end else begin
                mem_addr_nxt  = i_addr;
            end
        end
        if (cap_last) begin
            if (gnt_d) begin
                d_ack_nxt = 1'b1;
            end else begin
                i_ack_nxt = 1'b1;
            end
        end
    end

    // Output registers: everything leaving the block comes straight from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
        end
    end

    // Grant bookkeeping, latency counter and read-data capture for the granted port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_d   <= 1'b0;
            hold_we <= 1'b0;
            cnt     <= 4'd0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grant_now) begin
                gnt_d   <= pick_d;
                hold_we <= pick_d & d_we;
            end
            if (state == ST_ISSUE) begin
                cnt <= LAT_CNT;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // Stores leave both rdata registers untouched.
            if (cap_last && !hold_we) begin
                if (gnt_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timeline model.
// Latency model: access granted in IDLE cycle s -> strobe at s+1, ack at s+LAT+2, free at s+LAT+3.
// Backpressure: requesters hold req until ack, then reissue or drop at random.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int unsigned k);
        if (k == 16) return 32'h8C010004;  // byte address 0x40
        return (k * 32'h01000193) ^ 32'h5A5A5A5A;
    endfunction

    // ---------------- memory with fixed read latency ----------------
    logic [31:0] mem [256];
    bit          mem_ready = 1'b0;
    logic [31:0] pipe_d [LAT];
    bit          pipe_v [LAT];
    logic [31:0] junk;

    always @(posedge clock) begin
        junk <= $urandom;
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        pipe_v[0] <= mem_en && !mem_we;
        pipe_d[0] <= mem[mem_addr[9:2]];
        for (int k = 1; k < LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end

    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];
    logic [31:0] ref_i_rdata = '0;
    logic [31:0] ref_d_rdata = '0;
    bit          act = 1'b0;
    int          t_s = 0;
    bit          t_d, t_we;
    logic [31:0] t_addr, t_wdata;
    bit          m_last_d = 1'b0;
    int          cyc = 0;
    bit          seen_i_ack = 1'b0;
    bit          seen_d_ack = 1'b0;

    task automatic model_step();
        bit          e_en, e_we, e_busy, e_iack, e_dack;
        logic [31:0] e_addr, e_wdata;
        seen_i_ack = i_ack;
        seen_d_ack = d_ack;
        e_en = 0; e_we = 0; e_busy = 0; e_iack = 0; e_dack = 0;
        e_addr = '0; e_wdata = '0;
        if (!reset) begin
            act = 1'b0; m_last_d = 1'b0; ref_i_rdata = '0; ref_d_rdata = '0;
        end else begin
            if (act && cyc > t_s + LAT + 2) act = 1'b0;
            if (act) begin
                e_busy = (cyc >= t_s + 1);
                if (cyc == t_s + 1) begin
                    e_en = 1; e_we = t_we; e_addr = t_addr; e_wdata = t_wdata;
                    if (t_we) ref_mem[t_addr[9:2]] = t_wdata;
                end
                if (cyc == t_s + LAT + 2) begin
                    if (t_d) e_dack = 1; else e_iack = 1;
                    if (!t_we) begin
                        if (t_d) ref_d_rdata = ref_mem[t_addr[9:2]];
                        else     ref_i_rdata = ref_mem[t_addr[9:2]];
                    end
                end
            end
        end
        chk("busy",      busy,      e_busy);
        chk("mem_en",    mem_en,    e_en);
        chk("mem_we",    mem_we,    e_we);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("i_ack",     i_ack,     e_iack);
        chk("d_ack",     d_ack,     e_dack);
        chk("i_rdata",   i_rdata,   ref_i_rdata);
        chk("d_rdata",   d_rdata,   ref_d_rdata);
        // A free arbiter with a request pending this cycle grants it now.
        if (reset && !act && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef ARB_RR_EN
                t_d = !m_last_d;
`else
                t_d = 1'b1;
`endif
            end else begin
                t_d = d_req;
            end
            m_last_d = t_d;
            act = 1'b1;
            t_s = cyc;
            t_we    = t_d ? d_we : 1'b0;
            t_addr  = t_d ? d_addr : i_addr;
            t_wdata = t_d ? d_wdata : 32'h0;
        end
    endtask

    // ---------------- stimulus ----------------
    bit          auto_drv = 1'b0;
    int          p_new = 0;
    int          p_keep = 0;
    logic        nx_reset = 1'b0;
    logic        nx_i_req = 1'b0, nx_d_req = 1'b0, nx_d_we = 1'b0;
    logic [31:0] nx_i_addr = '0, nx_d_addr = '0, nx_d_wdata = '0;

    task automatic new_i();
        nx_i_req  = 1'b1;
        nx_i_addr = 32'($urandom_range(0, 63)) << 2;
    endtask

    task automatic new_d();
        nx_d_req   = 1'b1;
        nx_d_we    = 1'($urandom_range(0, 1));
        nx_d_addr  = 32'($urandom_range(0, 63)) << 2;
        nx_d_wdata = $urandom;
    endtask

    task automatic drive_ports();
        if (seen_i_ack) begin
            if ($urandom_range(0, 99) < p_keep) new_i(); else nx_i_req = 1'b0;
        end else if (!nx_i_req && $urandom_range(0, 99) < p_new) begin
            new_i();
        end
        if (seen_d_ack) begin
            if ($urandom_range(0, 99) < p_keep) new_d(); else nx_d_req = 1'b0;
        end else if (!nx_d_req && $urandom_range(0, 99) < p_new) begin
            new_d();
        end
    endtask

    task automatic apply_inputs();
        reset   = nx_reset;
        i_req   = nx_i_req;   i_addr  = nx_i_addr;
        d_req   = nx_d_req;   d_we    = nx_d_we;
        d_addr  = nx_d_addr;  d_wdata = nx_d_wdata;
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        if (auto_drv) drive_ports();
        apply_inputs();
        @(negedge clock);
        model_step();
    endtask

    task automatic run_until_ack(input bit port_d, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            tick();
            got = port_d ? seen_d_ack : seen_i_ack;
        end
        if (!got) chk(port_d ? "timeout_d_ack" : "timeout_i_ack", 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);

        // Reset state is checked every cycle by the model while reset is low.
        repeat (3) tick();
        nx_reset = 1'b1;
        tick();

        // Single fetch from 0x40.
        nx_i_req = 1'b1; nx_i_addr = 32'h40;
        c0 = cyc + 1;
        run_until_ack(1'b0, 20);
        chk("t1_latency", 32'(cyc - c0), 32'(LAT + 2));
        chk("t1_i_rdata", i_rdata, 32'h8C010004);
        nx_i_req = 1'b0;
        tick();

        // Store then load at 0x100.
        nx_d_req = 1'b1; nx_d_we = 1'b1; nx_d_addr = 32'h100; nx_d_wdata = 32'hDEADBEEF;
        run_until_ack(1'b1, 20);
        chk("t2_store_keeps_rdata", d_rdata, 32'h0);
        nx_d_we = 1'b0;  // kept high: a new access (load) in the following IDLE cycle
        run_until_ack(1'b1, 20);
        chk("t2_load_data", d_rdata, 32'hDEADBEEF);
        nx_d_req = 1'b0;
        tick();

        // Simultaneous requests: data first, then fetch.
        nx_i_req = 1'b1; nx_i_addr = 32'h8;
        nx_d_req = 1'b1; nx_d_we = 1'b0; nx_d_addr = 32'h40;
        c0 = cyc + 1;
        for (int n = 0; n < 20 && !(seen_i_ack || seen_d_ack); n++) tick();
        chk("t3_first_is_data", {31'd0, seen_d_ack}, 32'd1);
        chk("t3_d_ack_cycle", 32'(cyc - c0), 32'(LAT + 2));
        nx_d_req = 1'b0;
        run_until_ack(1'b0, 20);
        chk("t3_i_ack_cycle", 32'(cyc - c0), 32'(2 * LAT + 5));
        nx_i_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a fetch's WAIT phase.
        nx_i_req = 1'b1; nx_i_addr = 32'h10;
        tick(); tick();
        @(posedge clock);
        cyc++;
        #1;
        apply_inputs();
        chk("t5_busy_before_reset", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0; nx_reset = 1'b0;
        #1;
        chk("t5_async_busy",   {31'd0, busy},   32'd0);
        chk("t5_async_i_ack",  {31'd0, i_ack},  32'd0);
        chk("t5_async_i_rdata", i_rdata,        32'd0);
        chk("t5_async_d_rdata", d_rdata,        32'd0);
        @(negedge clock);
        model_step();
        tick(); tick();
        nx_reset = 1'b1;
        c0 = cyc + 1;
        run_until_ack(1'b0, 20);
        chk("t5_fresh_latency", 32'(cyc - c0), 32'(LAT + 2));
        nx_i_req = 1'b0;
        tick();

        // Randomized traffic at increasing load; the model checks every cycle.
        auto_drv = 1'b1;
        p_new = 30;  p_keep = 0;   repeat (1500) tick();
        p_new = 70;  p_keep = 50;  repeat (1500) tick();
        p_new = 100; p_keep = 100; repeat (1500) tick();
        auto_drv = 1'b0;
        nx_i_req = 1'b0; nx_d_req = 1'b0;
        repeat (LAT + 6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
